// File: rtl/game_pkg.sv
// Shared types and constants for the ball/collision-map logic.
// The probe indices also set the order in which the probes are issued to the collision ROMs.
package game_pkg;

    localparam int H_RES_DEF = 800;
    localparam int V_RES_DEF = 600;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ISSUE,
        DRAIN,
        DONE
    } probe_state_t;

    typedef logic signed [11:0] coord_s_t;
    typedef logic [18:0]        rom_addr_t;

    // Probe order: right, left, below, above the predicted centre.
    localparam int PRB_XP = 0;
    localparam int PRB_XN = 1;
    localparam int PRB_YP = 2;
    localparam int PRB_YN = 3;

endpackage

// File: rtl/probe_addr_gen.sv
// Maps a signed probe coordinate to a clamped collision-ROM address.
// It also flags a probe that falls outside the screen.
module probe_addr_gen
    import game_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic signed [11:0] px_i,
    input  logic signed [11:0] py_i,
    output logic [18:0]        addr_o,
    output logic               oob_o
);

    localparam coord_s_t X_MAX = coord_s_t'(H_RES - 1);
    localparam coord_s_t Y_MAX = coord_s_t'(V_RES - 1);

    logic      x_lo, x_hi, y_lo, y_hi;
    rom_addr_t cx, cy;

    always_comb begin
        x_lo = px_i[11];
        y_lo = py_i[11];
        x_hi = px_i > X_MAX;
        y_hi = py_i > Y_MAX;

        cx = rom_addr_t'(px_i);
        if (x_lo) begin
            cx = '0;
        end else if (x_hi) begin
            cx = rom_addr_t'(H_RES - 1);
        end

        cy = rom_addr_t'(py_i);
        if (y_lo) begin
            cy = '0;
        end else if (y_hi) begin
            cy = rom_addr_t'(V_RES - 1);
        end

        // The largest address on screen, (V_RES-1)*H_RES + H_RES-1, fits in 19 bits.
        addr_o = cy * rom_addr_t'(H_RES) + cx;
        oob_o  = x_lo | x_hi | y_lo | y_hi;
    end

endmodule

// File: rtl/collision_probe_sequencer.sv
// Per-frame sequencer: predicts the next ball position, then reads four perimeter probes from the shared-address collision ROMs.
// It then returns the reverse-x and reverse-y flags with a done pulse.
module collision_probe_sequencer
    import game_pkg::*;
#(
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int RADIUS  = 10,
    parameter int ROM_LAT = 1
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  ball_x,
    input  logic [9:0]  ball_y,
    input  logic [9:0]  speed_x,
    input  logic [9:0]  speed_y,
    output logic [18:0] rom_addr,
    output logic        rom_en,
    input  logic        rom_x_data,
    input  logic        rom_y_data,
    output logic        busy,
    output logic        done,
    output logic        coll_x,
    output logic        coll_y
);

    generate
        if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_bad_rom_lat
            $error("collision_probe_sequencer: ROM_LAT must be in 1..4");
        end
    endgenerate

    localparam coord_s_t RAD = coord_s_t'(RADIUS);

    probe_state_t state_q;
    logic [9:0]   bx_q, by_q, sx_q, sy_q;
    coord_s_t     px_q [4];
    coord_s_t     py_q [4];
    coord_s_t     calc_px [4];
    coord_s_t     calc_py [4];
    coord_s_t     nx, ny, sel_px, sel_py;
    rom_addr_t    gen_addr, rom_addr_q;
    logic         gen_oob, rom_en_q;
    logic [1:0]   rom_idx_q, next_idx;
    logic [3:0]   oob_q, hit_q, hit_d;
    logic [ROM_LAT-1:0] tag_v_q;
    logic [1:0]   tag_idx_q [ROM_LAT];
    logic         cap_v, cap_bit;
    logic [1:0]   cap_idx;
    logic         busy_q, done_q, coll_x_q, coll_y_q;

    assign nx = coord_s_t'({2'b00, bx_q}) + coord_s_t'($signed(sx_q));
    assign ny = coord_s_t'({2'b00, by_q}) + coord_s_t'($signed(sy_q));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_probe
            assign calc_px[gi] = (gi == PRB_XP) ? nx + RAD :
                                 (gi == PRB_XN) ? nx - RAD : nx;
            assign calc_py[gi] = (gi == PRB_YP) ? ny + RAD :
                                 (gi == PRB_YN) ? ny - RAD : ny;
        end
    endgenerate

    // The address generator works one probe ahead so that rom_addr can be a register.
    assign next_idx = rom_idx_q + 2'd1;

    always_comb begin
        sel_px = px_q[next_idx];
        sel_py = py_q[next_idx];
        if (state_q == CALC) begin
            sel_px = calc_px[PRB_XP];
            sel_py = calc_py[PRB_XP];
        end
    end

    probe_addr_gen #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_probe_addr_gen (
        .px_i   (sel_px),
        .py_i   (sel_py),
        .addr_o (gen_addr),
        .oob_o  (gen_oob)
    );

    // Returning ROM data is used only when a tag marks it as the reply to an issued probe.
    assign cap_v   = tag_v_q[ROM_LAT-1];
    assign cap_idx = tag_idx_q[ROM_LAT-1];
    assign cap_bit = cap_idx[1] ? rom_y_data : rom_x_data;
    assign hit_d   = hit_q | ({3'b000, cap_v & cap_bit} << cap_idx);

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_q <= '0;
            for (int k = 0; k < ROM_LAT; k++) begin
                tag_idx_q[k] <= 2'd0;
            end
        end else begin
            tag_v_q[0]   <= rom_en_q;
            tag_idx_q[0] <= rom_idx_q;
            for (int k = 1; k < ROM_LAT; k++) begin
                tag_v_q[k]   <= tag_v_q[k-1];
                tag_idx_q[k] <= tag_idx_q[k-1];
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bx_q       <= '0;
            by_q       <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            for (int p = 0; p < 4; p++) begin
                px_q[p] <= '0;
                py_q[p] <= '0;
            end
            rom_addr_q <= '0;
            rom_en_q   <= 1'b0;
            rom_idx_q  <= 2'd0;
            oob_q      <= '0;
            hit_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            coll_x_q   <= 1'b0;
            coll_y_q   <= 1'b0;
        end else begin
            hit_q <= hit_d;
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        bx_q    <= ball_x;
                        by_q    <= ball_y;
                        sx_q    <= speed_x;
                        sy_q    <= speed_y;
                        hit_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    for (int p = 0; p < 4; p++) begin
                        px_q[p] <= calc_px[p];
                        py_q[p] <= calc_py[p];
                    end
                    rom_addr_q <= gen_addr;
                    rom_en_q   <= 1'b1;
                    rom_idx_q  <= 2'd0;
                    oob_q      <= {3'b000, gen_oob};
                    state_q    <= ISSUE;
                end
                ISSUE: begin
                    if (rom_idx_q == 2'(PRB_YN)) begin
                        rom_en_q <= 1'b0;
                        state_q  <= DRAIN;
                    end else begin
                        rom_addr_q      <= gen_addr;
                        rom_idx_q       <= next_idx;
                        oob_q[next_idx] <= gen_oob;
                    end
                end
                DRAIN: begin
                    if (cap_v && cap_idx == 2'(PRB_YN)) begin
                        coll_x_q <= hit_d[PRB_XP] | hit_d[PRB_XN] | oob_q[PRB_XP] | oob_q[PRB_XN];
                        coll_y_q <= hit_d[PRB_YP] | hit_d[PRB_YN] | oob_q[PRB_YP] | oob_q[PRB_YN];
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rom_addr = rom_addr_q;
    assign rom_en   = rom_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign coll_x   = coll_x_q;
    assign coll_y   = coll_y_q;

endmodule

// File: tb/tb_collision_probe_sequencer.sv
// Bench for collision_probe_sequencer: ROM_LAT=1 and ROM_LAT=3 instances share the stimulus and each has its own ROM model and scoreboard.
module tb_collision_probe_sequencer;

    localparam int H = 800;
    localparam int V = 600;
    localparam int R = 10;

    typedef struct {
        logic cx;
        logic cy;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  ball_x = '0, ball_y = '0, speed_x = '0, speed_y = '0;

    logic [18:0] rom_addr_w [2];
    logic        rom_en_w   [2];
    logic        rom_x_w    [2];
    logic        rom_y_w    [2];
    logic        busy_w     [2];
    logic        done_w     [2];
    logic        coll_x_w   [2];
    logic        coll_y_w   [2];

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;
    int lat [2] = '{1, 3};
    int acc [2] = '{-1, -1};
    int idle_from [2] = '{0, 0};
    int xhit = -1;
    int yhit = -1;
    int cur_bx, cur_by, cur_sx, cur_sy;

    int   addr_q0 [$];
    int   addr_q1 [$];
    res_t res_q0 [$];
    res_t res_q1 [$];

    logic [3:0] xpipe [2] = '{4'hF, 4'hF};
    logic [3:0] ypipe [2] = '{4'hF, 4'hF};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    collision_probe_sequencer #(.ROM_LAT(1)) u_dut_l1 (
        .pixel_clk (clk), .rst_n (rst_n), .start (start),
        .ball_x (ball_x), .ball_y (ball_y), .speed_x (speed_x), .speed_y (speed_y),
        .rom_addr (rom_addr_w[0]), .rom_en (rom_en_w[0]),
        .rom_x_data (rom_x_w[0]), .rom_y_data (rom_y_w[0]),
        .busy (busy_w[0]), .done (done_w[0]), .coll_x (coll_x_w[0]), .coll_y (coll_y_w[0])
    );

    collision_probe_sequencer #(.ROM_LAT(3)) u_dut_l3 (
        .pixel_clk (clk), .rst_n (rst_n), .start (start),
        .ball_x (ball_x), .ball_y (ball_y), .speed_x (speed_x), .speed_y (speed_y),
        .rom_addr (rom_addr_w[1]), .rom_en (rom_en_w[1]),
        .rom_x_data (rom_x_w[1]), .rom_y_data (rom_y_w[1]),
        .busy (busy_w[1]), .done (done_w[1]), .coll_x (coll_x_w[1]), .coll_y (coll_y_w[1])
    );

    // ROM model: the only set bits are at xhit and yhit.
    // Cycles with no read return 1s, so that a stray capture shows up in the results.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            xpipe[i] <= {xpipe[i][2:0], rom_en_w[i] ? (int'(rom_addr_w[i]) == xhit) : 1'b1};
            ypipe[i] <= {ypipe[i][2:0], rom_en_w[i] ? (int'(rom_addr_w[i]) == yhit) : 1'b1};
        end
    end
    assign rom_x_w[0] = xpipe[0][0];
    assign rom_y_w[0] = ypipe[0][0];
    assign rom_x_w[1] = xpipe[1][2];
    assign rom_y_w[1] = ypipe[1][2];

    task automatic check(input string tag, input int got, input int exp);
        n_assert++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_model(input int i);
        int   px [4];
        int   py [4];
        int   cx, cy, a;
        logic oob, hit [4];
        res_t r;
        px = '{cur_bx + cur_sx + R, cur_bx + cur_sx - R, cur_bx + cur_sx, cur_bx + cur_sx};
        py = '{cur_by + cur_sy, cur_by + cur_sy, cur_by + cur_sy + R, cur_by + cur_sy - R};
        for (int p = 0; p < 4; p++) begin
            oob = (px[p] < 0) || (px[p] > H - 1) || (py[p] < 0) || (py[p] > V - 1);
            cx  = (px[p] < 0) ? 0 : (px[p] > H - 1) ? H - 1 : px[p];
            cy  = (py[p] < 0) ? 0 : (py[p] > V - 1) ? V - 1 : py[p];
            a   = cy * H + cx;
            hit[p] = oob || (p < 2 ? (a == xhit) : (a == yhit));
            if (i == 0) addr_q0.push_back(a);
            else        addr_q1.push_back(a);
        end
        r.cx = hit[0] | hit[1];
        r.cy = hit[2] | hit[3];
        if (i == 0) res_q0.push_back(r);
        else        res_q1.push_back(r);
    endtask

    task automatic set_ball(input int bx, input int by, input int sx, input int sy,
                            input int xh, input int yh);
        cur_bx = bx; cur_by = by; cur_sx = sx; cur_sy = sy;
        ball_x = 10'(bx); ball_y = 10'(by); speed_x = 10'(sx); speed_y = 10'(sy);
        xhit = xh; yhit = yh;
    endtask

    task automatic step(input logic v);
        @(posedge clk);
        #1;
        start = v;
        if (v) begin
            for (int i = 0; i < 2; i++) begin
                if (cyc >= idle_from[i]) begin
                    acc[i] = cyc;
                    idle_from[i] = cyc + 7 + lat[i];
                    push_model(i);
                end
            end
        end
    endtask

    task automatic wait_idle();
        while (cyc < idle_from[0] + 1 || cyc < idle_from[1] + 1) step(1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_busy%0d", tag, i), int'(busy_w[i]), 0);
            check($sformatf("%s_done%0d", tag, i), int'(done_w[i]), 0);
            check($sformatf("%s_en%0d", tag, i), int'(rom_en_w[i]), 0);
            check($sformatf("%s_collx%0d", tag, i), int'(coll_x_w[i]), 0);
            check($sformatf("%s_colly%0d", tag, i), int'(coll_y_w[i]), 0);
            check($sformatf("%s_addr%0d", tag, i), int'(rom_addr_w[i]), 0);
        end
    endtask

    task automatic monitor(input int i);
        logic e_busy, e_en, e_done;
        int   ea;
        res_t r;
        e_busy = acc[i] >= 0 && cyc > acc[i] && cyc <= acc[i] + 6 + lat[i];
        e_en   = acc[i] >= 0 && cyc >= acc[i] + 2 && cyc <= acc[i] + 5;
        e_done = acc[i] >= 0 && cyc == acc[i] + 6 + lat[i];
        check($sformatf("busy%0d", i), int'(busy_w[i]), int'(e_busy));
        check($sformatf("rom_en%0d", i), int'(rom_en_w[i]), int'(e_en));
        check($sformatf("done%0d", i), int'(done_w[i]), int'(e_done));
        if (rom_en_w[i]) begin
            if ((i == 0 ? addr_q0.size() : addr_q1.size()) == 0) begin
                check($sformatf("addr_underflow%0d", i), 1, 0);
            end else begin
                ea = (i == 0) ? addr_q0.pop_front() : addr_q1.pop_front();
                check($sformatf("rom_addr%0d", i), int'(rom_addr_w[i]), ea);
            end
        end
        if (done_w[i]) begin
            if ((i == 0 ? res_q0.size() : res_q1.size()) == 0) begin
                check($sformatf("res_underflow%0d", i), 1, 0);
            end else begin
                r = (i == 0) ? res_q0.pop_front() : res_q1.pop_front();
                check($sformatf("coll_x%0d", i), int'(coll_x_w[i]), int'(r.cx));
                check($sformatf("coll_y%0d", i), int'(coll_y_w[i]), int'(r.cy));
                $display("seq lat=%0d start@%0d done@%0d coll_x=%0d coll_y=%0d (exp %0d %0d)",
                         lat[i], acc[i], cyc, coll_x_w[i], coll_y_w[i], r.cx, r.cy);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) monitor(i);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        step(1'b0);
        step(1'b0);

        // Open field
        set_ball(200, 300, 0, 0, -1, -1);
        step(1'b1);
        wait_idle();

        // Wall hit on the right-hand probe
        set_ball(400, 300, 5, 0, 300 * H + 415, -1);
        step(1'b1);
        wait_idle();

        // Busy rejection: the extra pulses land at T+3 and at T+7, the ROM_LAT=1 DONE cycle
        set_ball(100, 100, 3, -2, -1, -1);
        step(1'b1);
        step(1'b0); step(1'b0);
        step(1'b1);
        step(1'b0); step(1'b0); step(1'b0);
        step(1'b1);
        step(1'b0);
        wait_idle();

        // Start held high, with a hit on the upper probe only
        set_ball(300, 200, -7, 9, -1, 199 * H + 293);
        for (int k = 0; k < 18; k++) step(1'b1);
        step(1'b0);
        wait_idle();

        // Screen edge: probes clamped on the left and bottom
        set_ball(5, 590, -3, 4, -1, -1);
        step(1'b1);
        wait_idle();

        // Corner maximum
        set_ball(799, 599, 0, 0, -1, -1);
        step(1'b1);
        wait_idle();

        // Asynchronous reset during ISSUE index 2
        set_ball(400, 300, 5, 0, 300 * H + 415, -1);
        step(1'b1);
        for (int k = 0; k < 4; k++) step(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        acc[0] = -1; acc[1] = -1;
        idle_from[0] = 0; idle_from[1] = 0;
        addr_q0.delete(); addr_q1.delete();
        res_q0.delete(); res_q1.delete();
        step(1'b0);
        step(1'b0);
        rst_n = 1'b1;
        step(1'b0);
        step(1'b1);
        wait_idle();

        check("leftover_addr0", addr_q0.size(), 0);
        check("leftover_addr1", addr_q1.size(), 0);
        check("leftover_res0", res_q0.size(), 0);
        check("leftover_res1", res_q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
